// File: rtl/line_arb_pkg.sv
// Shared definitions for the lineArb round-robin scheduler: default sizes, FSM state type
// and the index-width helper.
package line_arb_pkg;

  localparam int unsigned N_IN_DEF        = 8;
  localparam int unsigned DATA_W_DEF      = 64;
  localparam int unsigned STALL_LIMIT_DEF = 1023;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/line_arb_rr_pick.sv
// Round-robin pick: rotate the request vector so the search starts just above last_ptr,
// priority-encode the lowest set bit, then rotate the index back.
module line_arb_rr_pick
  import line_arb_pkg::*;
#(
  parameter int unsigned N_IN  = N_IN_DEF,
  parameter int unsigned IDX_W = clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [IDX_W-1:0] last_ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [N_IN-1:0]  rot;
  logic [IDX_W-1:0] off;
  int unsigned      start;

  always_comb begin
    start = (32'(last_ptr) + 32'd1) % N_IN;
    for (int unsigned i = 0; i < N_IN; i++) begin
      rot[i] = req[IDX_W'((start + i) % N_IN)];
    end
    off = '0;
    for (int i = int'(N_IN) - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    any = |req;
    idx = IDX_W'((start + 32'(off)) % N_IN);
  end

endmodule

// File: rtl/line_arb_rr_scheduler.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream output among N_IN inputs,
// with per-input stall supervision driving a registered block-flag vector.
module line_arb_rr_scheduler
  import line_arb_pkg::*;
#(
  parameter int unsigned N_IN        = N_IN_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned STALL_LIMIT = STALL_LIMIT_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_IN-1:0]          en_mask,
  input  logic [N_IN-1:0]          s_tvalid,
  input  logic [N_IN*DATA_W-1:0]   s_tdata,
  input  logic [N_IN-1:0]          s_tlast,
  output logic [N_IN-1:0]          s_tready,
  output logic                     m_tvalid,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tlast,
  output logic [clog2(N_IN)-1:0]   m_tdest,
  input  logic                     m_tready,
  output logic                     busy,
  output logic [N_IN-1:0]          block_sigs
);

  localparam int unsigned IDX_W = clog2(N_IN);
  localparam int unsigned CNT_W = clog2(STALL_LIMIT + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             sel_valid, sel_last;

  line_arb_rr_pick #(
    .N_IN  (N_IN),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (s_tvalid & en_mask),
    .last_ptr (last_ptr_q),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  assign sel_valid = s_tvalid[grant_q];
  assign sel_last  = s_tlast[grant_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      last_ptr_q <= IDX_W'(N_IN - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  // en_mask only gates new grants; an open packet always runs to its tlast.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_ptr_d = last_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (sel_valid && m_tready && sel_last) begin
          last_ptr_d = grant_q;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    m_tdest  = '0;
    busy     = 1'b0;
    if (state_q == StBusy) begin
      m_tvalid          = sel_valid;
      m_tdata           = s_tdata[32'(grant_q) * DATA_W +: DATA_W];
      m_tlast           = sel_last;
      m_tdest           = grant_q;
      s_tready[grant_q] = m_tready;
      busy              = 1'b1;
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_stall
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blk_q;

    always_comb begin
      if (!s_tvalid[g] || s_tready[g]) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(STALL_LIMIT)) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_q <= '0;
        blk_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        blk_q <= (cnt_d == CNT_W'(STALL_LIMIT));
      end
    end

    assign block_sigs[g] = blk_q;
  end

endmodule

// File: tb/tb_line_arb_rr_scheduler.sv
// Scoreboard bench for line_arb_rr_scheduler: per-input packet sources, an expected-beat
// queue filled in predicted grant order, and timing checks on handshakes and block flags.
module tb_line_arb_rr_scheduler;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned SL = 4;
  localparam int unsigned IW = 3;
  localparam int unsigned MAXB = 16;

  logic          clock;
  logic          reset;
  logic [N-1:0]  en_mask;
  logic [N-1:0]  s_tvalid;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]  s_tlast;
  logic [N-1:0]  s_tready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [IW-1:0] m_tdest;
  logic          m_tready;
  logic          busy;
  logic [N-1:0]  block_sigs;

  line_arb_rr_scheduler #(
    .N_IN        (N),
    .DATA_W      (DW),
    .STALL_LIMIT (SL)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .en_mask    (en_mask),
    .s_tvalid   (s_tvalid),
    .s_tdata    (s_tdata),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_tvalid   (m_tvalid),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tdest    (m_tdest),
    .m_tready   (m_tready),
    .busy       (busy),
    .block_sigs (block_sigs)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [IW-1:0] dest;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  int            hs_cyc[$];
  logic [DW-1:0] src_data [N][MAXB];
  logic          src_last [N][MAXB];
  int            src_cnt  [N];
  int            src_pos  [N];
  int            n_cmp, n_err, cyc, pkt_seq, blk_rise, blk_fall;

  logic          smp_busy, smp_mvalid, smp_mlast;
  logic [IW-1:0] smp_mdest;
  logic [N-1:0]  smp_sready, smp_block;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_pos[i] < src_cnt[i]) begin
        s_tvalid[i]          = 1'b1;
        s_tdata[i*DW +: DW]  = src_data[i][src_pos[i]];
        s_tlast[i]           = src_last[i][src_pos[i]];
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tdata[i*DW +: DW]  = '0;
        s_tlast[i]           = 1'b0;
      end
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      src_cnt[i] = 0;
      src_pos[i] = 0;
    end
  endtask

  task automatic load_pkt(input int i, input int nbeats, input bit push);
    logic [DW-1:0] d;
    for (int b = 0; b < nbeats; b++) begin
      d = {8'(i), 8'(pkt_seq), 16'(b)};
      src_data[i][src_cnt[i]] = d;
      src_last[i][src_cnt[i]] = (b == nbeats - 1);
      src_cnt[i]++;
      if (push) exp_q.push_back('{dest: IW'(i), data: d, last: (b == nbeats - 1)});
    end
    pkt_seq++;
  endtask

  // Sample at the falling edge, advance sources just after the rising edge.
  task automatic cycle();
    logic [N-1:0] hs;
    beat_t        e;
    @(negedge clock);
    hs         = s_tvalid & s_tready;
    smp_busy   = busy;
    smp_mvalid = m_tvalid;
    smp_mlast  = m_tlast;
    smp_mdest  = m_tdest;
    smp_sready = s_tready;
    smp_block  = block_sigs;
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_beat", 64'(m_tdata), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check_eq("tdest", 64'(m_tdest), 64'(e.dest));
        check_eq("tdata", 64'(m_tdata), 64'(e.data));
        check_eq("tlast", 64'(m_tlast), 64'(e.last));
        hs_cyc.push_back(cyc);
      end
    end
    if (block_sigs[3] && blk_rise < 0) blk_rise = cyc;
    if (!block_sigs[3] && blk_rise >= 0 && blk_fall < 0) blk_fall = cyc;
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (hs[i]) src_pos[i]++;
    drive();
  endtask

  task automatic run_until_empty(input int max);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < max) begin
      cycle();
      k++;
    end
    if (exp_q.size() != 0) begin
      check_eq("timeout", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    m_tready = 1'b0;
    en_mask  = '1;
    clear_sources();
    drive();
    cycle();
    cycle();
    reset    = 1'b0;
    m_tready = 1'b1;
    hs_cyc.delete();
    cyc      = 0;
  endtask

  task automatic start_test();
    drive();
    hs_cyc.delete();
    cyc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; pkt_seq = 0; blk_rise = -1; blk_fall = -1;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0;
    apply_reset();

    // Reset state
    cycle();
    check_eq("rst_busy", 64'(smp_busy), 64'(0));
    check_eq("rst_mvalid", 64'(smp_mvalid), 64'(0));
    check_eq("rst_mlast", 64'(smp_mlast), 64'(0));
    check_eq("rst_mdest", 64'(smp_mdest), 64'(0));
    check_eq("rst_sready", 64'(smp_sready), 64'(0));
    check_eq("rst_block", 64'(smp_block), 64'(0));

    // Single 3-beat packet on input 0: request in cycle 0, beats in cycles 1..3
    load_pkt(0, 3, 1);
    start_test();
    run_until_empty(20);
    for (int k = 0; k < 3; k++) check_eq("t1_beat_cyc", 64'(hs_cyc[k]), 64'(k + 1));
    cycle();
    check_eq("t1_busy_fall", 64'(smp_busy), 64'(0));

    // All inputs requesting 1-beat packets: order 0..7,0, one packet per two cycles
    apply_reset();
    for (int i = 0; i < N; i++) load_pkt(i, 1, 1);
    load_pkt(0, 1, 1);
    start_test();
    run_until_empty(40);
    for (int k = 0; k < 9; k++) check_eq("t2_pkt_cyc", 64'(hs_cyc[k]), 64'(2 * k + 1));

    // Wrap: serve input 2 first so last_ptr=2, then 0 and 1 compete
    apply_reset();
    load_pkt(2, 1, 1);
    start_test();
    run_until_empty(10);
    load_pkt(0, 1, 1);
    load_pkt(1, 1, 1);
    start_test();
    run_until_empty(10);

    // Masking: input 0 disabled, input 1 mask cleared mid-packet
    apply_reset();
    en_mask = 8'hFE;
    load_pkt(0, 2, 0);
    load_pkt(1, 3, 1);
    start_test();
    cycle();
    cycle();
    en_mask = 8'hFC;
    run_until_empty(20);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_eq("t4_idle_busy", 64'(smp_busy), 64'(0));
      check_eq("t4_idle_sready", 64'(smp_sready), 64'(0));
    end
    check_eq("t4_in0_waiting", 64'(src_pos[0]), 64'(0));

    // Stall supervision: input 3 waits while input 5 sends a 10-beat packet
    apply_reset();
    blk_rise = -1;
    blk_fall = -1;
    load_pkt(5, 10, 1);
    start_test();
    cycle();
    load_pkt(3, 1, 1);
    drive();
    run_until_empty(40);
    cycle();
    cycle();
    check_eq("t5_hs3_cyc", 64'(hs_cyc[hs_cyc.size() - 1]), 64'(12));
    check_eq("t5_blk_rise", 64'(blk_rise), 64'(5));
    check_eq("t5_blk_fall", 64'(blk_fall), 64'(hs_cyc[hs_cyc.size() - 1] + 1));
    check_eq("t5_blk_final", 64'(smp_block), 64'(0));

    // Reset mid-packet: last_ptr=1 beforehand, then input 4 held by m_tready=0
    apply_reset();
    load_pkt(1, 1, 1);
    start_test();
    run_until_empty(10);
    m_tready = 1'b0;
    load_pkt(4, 3, 0);
    drive();
    cycle();
    cycle();
    cycle();
    check_eq("t6_busy", 64'(smp_busy), 64'(1));
    check_eq("t6_mdest", 64'(smp_mdest), 64'(4));
    check_eq("t6_mvalid", 64'(smp_mvalid), 64'(1));
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    clear_sources();
    drive();
    cycle();
    check_eq("t6_busy_after", 64'(smp_busy), 64'(0));
    check_eq("t6_mvalid_after", 64'(smp_mvalid), 64'(0));
    check_eq("t6_mlast_after", 64'(smp_mlast), 64'(0));
    check_eq("t6_mdest_after", 64'(smp_mdest), 64'(0));
    check_eq("t6_sready_after", 64'(smp_sready), 64'(0));
    m_tready = 1'b1;
    load_pkt(0, 1, 1);
    load_pkt(2, 1, 1);
    start_test();
    run_until_empty(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
